// File: rtl/sv_uart_rx_packer.sv
// Packs the UART receiver byte stream into DATA_WIDTH-bit words (first byte in MSBs)
// and drops a partial word after TIMEOUT_BITS idle UART bit periods.
module sv_uart_rx_packer #(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [15:0]           idivider,
    output logic                  otimeout
);

    localparam int unsigned WORDS_NUM = DATA_WIDTH / 8;
    localparam int unsigned ACC_W     = DATA_WIDTH - 8;
    localparam int unsigned CNT_W     = $clog2(WORDS_NUM);
    localparam int unsigned BITS_W    = $clog2(TIMEOUT_BITS + 1);

    logic [CNT_W-1:0]      cnt;
    logic [ACC_W-1:0]      acc;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_vld;
    logic [15:0]           pre;
    logic [BITS_W-1:0]     bits;

    logic                  last_c;
    logic                  accept_c;
    logic                  count_c;
    logic                  tick_c;
    logic                  discard_c;
    logic [15:0]           div_m1_c;

    // Only the byte that would complete a word stalls behind a pending output word.
    always_comb begin
        last_c        = (cnt == CNT_W'(WORDS_NUM - 1));
        s_axis_tready = ~(last_c && out_vld && ~m_axis_tready);
        accept_c      = s_axis_tvalid && s_axis_tready;
        div_m1_c      = (idivider == 16'd0) ? 16'd0 : idivider - 16'd1;
        count_c       = (cnt != '0) && ~s_axis_tvalid;
        tick_c        = count_c && (pre == div_m1_c);
        discard_c     = tick_c && (bits == BITS_W'(TIMEOUT_BITS - 1));
    end

    assign m_axis_tdata  = out_dat;
    assign m_axis_tvalid = out_vld;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt      <= '0;
            acc      <= '0;
            out_dat  <= '0;
            out_vld  <= 1'b0;
            pre      <= '0;
            bits     <= '0;
            otimeout <= 1'b0;
        end else begin
            otimeout <= 1'b0;
            if (m_axis_tready) begin
                out_vld <= 1'b0;
            end
            // A byte accept always wins over a concurrent idle tick.
            if (accept_c) begin
                pre  <= '0;
                bits <= '0;
                if (last_c) begin
                    out_dat <= {acc, s_axis_tdata};
                    out_vld <= 1'b1;
                    cnt     <= '0;
                    acc     <= '0;
                end else begin
                    acc <= ACC_W'({acc, s_axis_tdata});
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (count_c) begin
                if (tick_c) begin
                    pre <= '0;
                    if (discard_c) begin
                        bits     <= '0;
                        cnt      <= '0;
                        acc      <= '0;
                        otimeout <= 1'b1;
                    end else begin
                        bits <= bits + BITS_W'(1);
                    end
                end else begin
                    pre <= pre + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// Self-checking bench for sv_uart_rx_packer: directed scenarios plus randomized traffic
// compared every cycle against a byte-queue / idle-cycle reference model.
module tb_sv_uart_rx_packer;

    localparam int unsigned DW = 24;
    localparam int unsigned TB = 20;
    localparam int unsigned WN = DW / 8;

    logic          iclk;
    logic          irst_n;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [15:0]   divider;
    logic          otimeout;

    sv_uart_rx_packer #(.DATA_WIDTH(DW), .TIMEOUT_BITS(TB)) dut (
        .iclk          (iclk),
        .irst_n        (irst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .idivider      (divider),
        .otimeout      (otimeout)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the partial word, pending output word, idle cycles seen.
    logic [7:0]    q[$];
    bit            mv;
    logic [DW-1:0] md;
    int            idle;
    bit            eto;
    logic [DW-1:0] got[$];
    logic          obs_to;
    logic          obs_vld;
    logic          obs_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dval();
        return (divider == 16'd0) ? 1 : int'(divider);
    endfunction

    task automatic model_reset();
        q.delete();
        mv   = 1'b0;
        md   = '0;
        idle = 0;
        eto  = 1'b0;
    endtask

    // One cycle: drive inputs after the falling edge, check, advance model, cross the rising edge.
    task automatic step(input logic tv, input logic [7:0] td, input logic mr);
        bit rdy;
        s_tvalid = tv;
        s_tdata  = td;
        m_tready = mr;
        #1;
        rdy     = !(q.size() == WN - 1 && mv && !mr);
        obs_to  = otimeout;
        obs_vld = m_tvalid;
        obs_rdy = s_tready;
        chk("s_axis_tready", 32'(s_tready), 32'(rdy));
        chk("m_axis_tvalid", 32'(m_tvalid), 32'(mv));
        chk("otimeout", 32'(otimeout), 32'(eto));
        if (mv) chk("m_axis_tdata", 32'(m_tdata), 32'(md));
        if (m_tvalid && mr) got.push_back(m_tdata);
        eto = 1'b0;
        if (mr) mv = 1'b0;
        if (tv && rdy) begin
            q.push_back(td);
            idle = 0;
            if (q.size() == WN) begin
                md = '0;
                foreach (q[i]) md = (md << 8) | DW'(q[i]);
                mv = 1'b1;
                q.delete();
            end
        end else if (q.size() != 0 && !tv) begin
            idle++;
            if (idle == dval() * int'(TB)) begin
                q.delete();
                idle = 0;
                eto  = 1'b1;
            end
        end
        @(posedge iclk);
        @(negedge iclk);
    endtask

    task automatic expect_words(input string name, input logic [DW-1:0] w0,
                                input logic [DW-1:0] w1, input int n);
        logic [DW-1:0] exp_w[2];
        exp_w[0] = w0;
        exp_w[1] = w1;
        chk({name, " word count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk({name, " word"}, 32'(got[i]), 32'(exp_w[i]));
        got.delete();
    endtask

    // Returns the number of edges after the last accept at which otimeout was first observed.
    task automatic idle_until_timeout(output int n);
        n = -1;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (obs_to && n < 0) n = i;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt_v;
        irst_n   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        divider  = 16'd1;
        model_reset();
        got.delete();
        #12;
        chk("reset tvalid", 32'(m_tvalid), 32'd0);
        chk("reset tdata", 32'(m_tdata), 32'd0);
        chk("reset otimeout", 32'(otimeout), 32'd0);
        chk("reset tready", 32'(s_tready), 32'd1);
        @(negedge iclk);
        irst_n = 1'b1;

        // Basic packing, MSB-first.
        step(1'b1, 8'hA1, 1'b1);
        step(1'b1, 8'hB2, 1'b1);
        step(1'b1, 8'hC3, 1'b1);
        cnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (obs_vld) cnt_v++;
        end
        chk("single-cycle valid", 32'(cnt_v), 32'd1);
        expect_words("basic", 24'hA1B2C3, 24'h0, 1);

        // Back-pressure: only the completing byte stalls.
        for (int b = 1; b <= 5; b++) step(1'b1, 8'(b), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h06, 1'b0);
            chk("stall tready", 32'(obs_rdy), 32'd0);
        end
        step(1'b1, 8'h06, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        expect_words("backpressure", 24'h010203, 24'h040506, 2);

        // Idle timeout with divider 4: 80 edges.
        divider = 16'd4;
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        idle_until_timeout(n);
        chk("timeout edges div4", 32'(n), 32'd80);
        step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        step(1'b1, 8'h55, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        expect_words("after timeout", 24'h334455, 24'h0, 1);

        // A stalled byte keeps the timeout frozen.
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        step(1'b1, 8'hCC, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        cnt_v = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 8'h33, 1'b0);
            if (obs_to) cnt_v++;
        end
        chk("no timeout while stalled", 32'(cnt_v), 32'd0);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        expect_words("stalled hold", 24'hAABBCC, 24'h112233, 2);

        // Divider 0 behaves as 1.
        divider = 16'd0;
        step(1'b1, 8'h5A, 1'b1);
        idle_until_timeout(n);
        chk("timeout edges div0", 32'(n), 32'd20);
        expect_words("div0", 24'h0, 24'h0, 0);

        // Asynchronous reset with a word pending and a partial word.
        divider = 16'd2;
        step(1'b1, 8'hD1, 1'b0);
        step(1'b1, 8'hD2, 1'b0);
        step(1'b1, 8'hD3, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #2;
        irst_n = 1'b0;
        #1;
        chk("async rst tvalid", 32'(m_tvalid), 32'd0);
        chk("async rst tdata", 32'(m_tdata), 32'd0);
        chk("async rst otimeout", 32'(otimeout), 32'd0);
        chk("async rst tready", 32'(s_tready), 32'd1);
        model_reset();
        got.delete();
        @(posedge iclk);
        @(negedge iclk);
        irst_n = 1'b1;
        step(1'b1, 8'h0A, 1'b1);
        step(1'b1, 8'h0B, 1'b1);
        step(1'b1, 8'h0C, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        expect_words("after reset", 24'h0A0B0C, 24'h0, 1);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 200; seg++) begin
            int mode;
            if (q.size() == 0 && $urandom_range(0, 3) == 0) divider = 16'($urandom_range(0, 4));
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                for (int i = 0; i < 20; i++)
                    step(1'($urandom_range(0, 9) < 8), 8'($urandom), 1'($urandom_range(0, 3) != 0));
            end else if (mode == 1) begin
                int len;
                len = int'($urandom_range(1, 100));
                for (int i = 0; i < len; i++) step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                for (int i = 0; i < 20; i++)
                    step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 4) == 0));
            end
        end
        got.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
